// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port memory between data access, instruction fetch
// and the loader port, one fixed-latency access at a time, with a loader starvation guard.
module mem_port_arbiter #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] fetch_addr,
  output logic             fetch_gnt,
  output logic             fetch_done,
  input  logic             data_req,
  input  logic             data_we,
  input  logic [WIDTH-1:0] data_addr,
  input  logic [WIDTH-1:0] data_wdata,
  output logic             data_gnt,
  output logic             data_done,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_wdata,
  output logic             ld_gnt,
  output logic             ld_done,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA, OWN_LD} owner_t;

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt, win;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SW-1:0]    starve_cnt, starve_nxt;

  logic             fetch_gnt_nxt, fetch_done_nxt;
  logic             data_gnt_nxt, data_done_nxt;
  logic             ld_gnt_nxt, ld_done_nxt;
  logic [WIDTH-1:0] rdata_nxt;
  logic             busy_nxt, mem_en_nxt, mem_we_nxt;
  logic [WIDTH-1:0] mem_addr_nxt, mem_wdata_nxt;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    cnt_nxt        = cnt;
    starve_nxt     = starve_cnt;
    win            = OWN_NONE;
    fetch_gnt_nxt  = 1'b0;
    fetch_done_nxt = 1'b0;
    data_gnt_nxt   = 1'b0;
    data_done_nxt  = 1'b0;
    ld_gnt_nxt     = 1'b0;
    ld_done_nxt    = 1'b0;
    rdata_nxt      = rdata;
    busy_nxt       = busy;
    mem_en_nxt     = mem_en;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;

    case (state)
      IDLE: begin
        if (ld_req && (starve_cnt == SW'(STARVE_LIMIT))) win = OWN_LD;
        else if (data_req)                                win = OWN_DATA;
        else if (fetch_req)                               win = OWN_FETCH;
        else if (ld_req)                                  win = OWN_LD;

        // Starvation counter only advances while the loader is actually waiting.
        if (!ld_req || (win == OWN_LD)) begin
          starve_nxt = '0;
        end else if ((win != OWN_NONE) && (starve_cnt != SW'(STARVE_LIMIT))) begin
          starve_nxt = starve_cnt + SW'(1);
        end

        if (win != OWN_NONE) begin
          state_nxt  = ACCESS;
          owner_nxt  = win;
          cnt_nxt    = CNT_W'(LATENCY - 1);
          mem_en_nxt = 1'b1;
          busy_nxt   = 1'b1;
          case (win)
            OWN_DATA: begin
              data_gnt_nxt  = 1'b1;
              mem_we_nxt    = data_we;
              mem_addr_nxt  = data_addr;
              mem_wdata_nxt = data_wdata;
            end
            OWN_FETCH: begin
              fetch_gnt_nxt = 1'b1;
              mem_we_nxt    = 1'b0;
              mem_addr_nxt  = fetch_addr;
              mem_wdata_nxt = '0;
            end
            default: begin
              ld_gnt_nxt    = 1'b1;
              mem_we_nxt    = ld_we;
              mem_addr_nxt  = ld_addr;
              mem_wdata_nxt = ld_wdata;
            end
          endcase
        end
      end

      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          if (!mem_we) rdata_nxt = mem_rdata;
          case (owner)
            OWN_DATA:  data_done_nxt  = 1'b1;
            OWN_FETCH: fetch_done_nxt = 1'b1;
            OWN_LD:    ld_done_nxt    = 1'b1;
            default:   ;
          endcase
          mem_en_nxt = 1'b0;
          mem_we_nxt = 1'b0;
          busy_nxt   = 1'b0;
          owner_nxt  = OWN_NONE;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      cnt        <= '0;
      starve_cnt <= '0;
      fetch_gnt  <= 1'b0;
      fetch_done <= 1'b0;
      data_gnt   <= 1'b0;
      data_done  <= 1'b0;
      ld_gnt     <= 1'b0;
      ld_done    <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      starve_cnt <= starve_nxt;
      fetch_gnt  <= fetch_gnt_nxt;
      fetch_done <= fetch_done_nxt;
      data_gnt   <= data_gnt_nxt;
      data_done  <= data_done_nxt;
      ld_gnt     <= ld_gnt_nxt;
      ld_done    <= ld_done_nxt;
      rdata      <= rdata_nxt;
      busy       <= busy_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LATENCY=2 instance with a latency-checking
// memory model, plus a LATENCY=1 instance for back-to-back fetches.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;

  logic        fetch_req, data_req, data_we, ld_req, ld_we;
  logic [15:0] fetch_addr, data_addr, data_wdata, ld_addr, ld_wdata;
  logic        fetch_gnt, fetch_done, data_gnt, data_done, ld_gnt, ld_done;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, mem_en, mem_we;

  logic        b_fetch_req;
  logic [15:0] b_fetch_addr;
  logic        b_fetch_gnt, b_fetch_done, b_data_gnt, b_data_done, b_ld_gnt, b_ld_done;
  logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_busy, b_mem_en, b_mem_we;

  logic [15:0] mem [0:255];
  logic [7:0]  en_cnt;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.WIDTH(16), .LATENCY(2), .STARVE_LIMIT(4)) u_dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_done(data_done),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_done(ld_done),
    .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.WIDTH(16), .LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clock(clock), .reset(reset),
    .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_gnt(b_fetch_gnt), .fetch_done(b_fetch_done),
    .data_req(1'b0), .data_we(1'b0), .data_addr(16'h0000), .data_wdata(16'h0000),
    .data_gnt(b_data_gnt), .data_done(b_data_done),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0000), .ld_wdata(16'h0000),
    .ld_gnt(b_ld_gnt), .ld_done(b_ld_done),
    .rdata(b_rdata), .busy(b_busy), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: read data is only valid once mem_en has been high for LATENCY cycles.
  always @(posedge clock) begin
    en_cnt <= mem_en ? en_cnt + 8'd1 : 8'd0;
    if (mem_en && mem_we) mem[mem_addr[7:0]] = mem_wdata;
  end
  assign mem_rdata   = (mem_en && en_cnt >= 8'd1) ? mem[mem_addr[7:0]] : 16'hDEAD;
  assign b_mem_rdata = b_mem_en ? (16'hA000 | b_mem_addr) : 16'hDEAD;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns 1=fetch, 2=data, 3=loader, 0 if no grant within the budget.
  task automatic wait_gnt(output int code);
    code = 0;
    for (int i = 0; i < 8 && code == 0; i++) begin
      @(negedge clock);
      if (data_gnt)       code = 2;
      else if (fetch_gnt) code = 1;
      else if (ld_gnt)    code = 3;
    end
  endtask

  // At most one grant per cycle, and never a grant together with a done.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      assert ((32'($countones({fetch_gnt, data_gnt, ld_gnt})) <= 1) &&
              !((fetch_gnt | data_gnt | ld_gnt) && (fetch_done | data_done | ld_done)))
      else begin
        failures++;
        $error("FAIL gnt_exclusive observed=%b%b%b/%b%b%b expected=onehot0,no-overlap",
               fetch_gnt, data_gnt, ld_gnt, fetch_done, data_done, ld_done);
      end
    end
  end

  initial begin
    int code;
    int exp_seq [10] = '{2, 1, 2, 1, 3, 2, 1, 2, 1, 3};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hC105;
    fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    b_fetch_req = 0; b_fetch_addr = 0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_mem_en", 16'(mem_en), 16'h0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_gnts", 16'({fetch_gnt, data_gnt, ld_gnt}), 16'h0);

    // Single fetch
    fetch_req = 1; fetch_addr = 16'h0010;
    tick(1);
    chk("f_gnt", 16'(fetch_gnt), 16'h1);
    chk("f_en1", 16'(mem_en), 16'h1);
    chk("f_addr", mem_addr, 16'h0010);
    chk("f_busy1", 16'(busy), 16'h1);
    fetch_req = 0;
    tick(1);
    chk("f_gnt_pulse", 16'(fetch_gnt), 16'h0);
    chk("f_en2", 16'(mem_en), 16'h1);
    chk("f_early_done", 16'(fetch_done), 16'h0);
    tick(1);
    chk("f_done", 16'(fetch_done), 16'h1);
    chk("f_rdata", rdata, 16'hC105);
    chk("f_busy_end", 16'(busy), 16'h0);
    chk("f_en_end", 16'(mem_en), 16'h0);
    tick(1);
    chk("f_done_pulse", 16'(fetch_done), 16'h0);

    // Store then load
    data_req = 1; data_we = 1; data_addr = 16'h0020; data_wdata = 16'hBEEF;
    tick(1);
    chk("st_gnt", 16'(data_gnt), 16'h1);
    chk("st_we", 16'(mem_we), 16'h1);
    chk("st_wdata", mem_wdata, 16'hBEEF);
    data_req = 0;
    tick(2);
    chk("st_done", 16'(data_done), 16'h1);
    chk("st_rdata_hold", rdata, 16'hC105);
    data_req = 1; data_we = 0; data_wdata = 16'h0000;
    tick(1);
    chk("ld_gnt_data", 16'(data_gnt), 16'h1);
    chk("ld_we0", 16'(mem_we), 16'h0);
    data_req = 0;
    tick(2);
    chk("ld_done_data", 16'(data_done), 16'h1);
    chk("ld_rdata", rdata, 16'hBEEF);

    // Contention: data beats fetch, fetch granted on the edge after data_done
    data_req = 1; data_we = 0; data_addr = 16'h0010;
    fetch_req = 1; fetch_addr = 16'h0020;
    tick(1);
    chk("ct_data_gnt", 16'(data_gnt), 16'h1);
    chk("ct_fetch_wait", 16'(fetch_gnt), 16'h0);
    data_req = 0;
    tick(2);
    chk("ct_data_done", 16'(data_done), 16'h1);
    chk("ct_rdata1", rdata, 16'hC105);
    tick(1);
    chk("ct_fetch_gnt", 16'(fetch_gnt), 16'h1);
    fetch_req = 0;
    tick(2);
    chk("ct_fetch_done", 16'(fetch_done), 16'h1);
    chk("ct_rdata2", rdata, 16'hBEEF);

    // Starvation: data/fetch alternate while the loader waits
    ld_req = 1; ld_we = 0; ld_addr = 16'h0010;
    data_req = 1; data_we = 0; data_addr = 16'h0020;
    fetch_req = 1; fetch_addr = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      wait_gnt(code);
      chk($sformatf("starve_seq%0d", k), 16'(code), 16'(exp_seq[k]));
      if (code == 2) data_req = 0;
      if (code == 1) data_req = 1;
    end
    ld_req = 0; data_req = 0; fetch_req = 0;
    tick(4);
    chk("starve_idle", 16'(busy), 16'h0);
    chk("starve_rdata", rdata, 16'hC105);

    // Reset mid-access aborts without a done
    data_req = 1; data_we = 0; data_addr = 16'h0020;
    tick(1);
    chk("ra_gnt", 16'(data_gnt), 16'h1);
    data_req = 0;
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("ra_no_done", 16'(data_done), 16'h0);
    chk("ra_mem_en", 16'(mem_en), 16'h0);
    chk("ra_busy", 16'(busy), 16'h0);
    chk("ra_rdata", rdata, 16'h0000);
    reset = 1'b0;
    tick(1);
    chk("ra_no_late_done", 16'(data_done), 16'h0);
    data_req = 1; data_addr = 16'h0010;
    tick(1);
    chk("ra_regnt", 16'(data_gnt), 16'h1);
    data_req = 0;
    tick(2);
    chk("ra_redone", 16'(data_done), 16'h1);
    chk("ra_rerdata", rdata, 16'hC105);

    // Loader write then data read back
    ld_req = 1; ld_we = 1; ld_addr = 16'h0030; ld_wdata = 16'h1234;
    tick(1);
    chk("lw_gnt", 16'(ld_gnt), 16'h1);
    chk("lw_addr", mem_addr, 16'h0030);
    ld_req = 0;
    tick(2);
    chk("lw_done", 16'(ld_done), 16'h1);
    data_req = 1; data_we = 0; data_addr = 16'h0030;
    tick(1);
    data_req = 0;
    tick(2);
    chk("lw_readback", rdata, 16'h1234);

    // LATENCY=1 instance: held fetch_req gives gnt/done every other cycle
    b_fetch_req = 1; b_fetch_addr = 16'h0040;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk($sformatf("l1_gnt%0d", k), 16'({b_fetch_gnt, b_fetch_done}), 16'h2);
      b_fetch_addr = b_fetch_addr + 16'h1;
      tick(1);
      chk($sformatf("l1_done%0d", k), 16'({b_fetch_gnt, b_fetch_done}), 16'h1);
      chk($sformatf("l1_rdata%0d", k), b_rdata, 16'hA040 + 16'(k));
    end
    b_fetch_req = 0;
    tick(2);
    chk("l1_idle", 16'(b_busy), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port 16-bit instruction/data memory between three requesters: instruction fetch (P1), load/store data access (P4), and an external program loader/debug port. Fixed priority data > fetch > loader, with a starvation guard for the loader. Each access is sequenced through a registered request/grant/done handshake and a fixed-latency memory access.

Parameters:
WIDTH, 16, data and address width
LATENCY, 2, memory read latency in cycles (>=1); mem_rdata valid LATENCY cycles after mem_en rises
STARVE_LIMIT, 4, consecutive non-loader grants while ld_req is pending before the loader is forced to win

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
fetch_req  in  1  instruction fetch request (read only)
fetch_addr  in  WIDTH  fetch address (PC)
fetch_gnt  out  1  one-cycle pulse: fetch accepted
fetch_done  out  1  one-cycle pulse: fetch complete, rdata valid
data_req  in  1  load/store request
data_we  in  1  1 = store, 0 = load
data_addr  in  WIDTH  data address
data_wdata  in  WIDTH  store data
data_gnt  out  1  one-cycle accept pulse
data_done  out  1  one-cycle completion pulse
ld_req  in  1  loader request
ld_we  in  1  1 = write, 0 = read
ld_addr  in  WIDTH  loader address
ld_wdata  in  WIDTH  loader write data
ld_gnt  out  1  one-cycle accept pulse
ld_done  out  1  one-cycle completion pulse
rdata  out  WIDTH  read data of last completed read
busy  out  1  access in flight
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data

Behaviour:
- Reset (sync, high): state=IDLE; all gnt/done, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, rdata = 0; starve_cnt = 0. Reset mid-access aborts it: no done pulse, mem_en drops on the next edge.
- States: IDLE, ACCESS. All outputs registered.
- IDLE, posedge with any req high: pick winner; latch mem_addr/mem_we/mem_wdata from the winner (fetch: we=0, wdata=0); mem_en=1; busy=1; owner=winner; winner gnt=1 for exactly one cycle; cnt=LATENCY-1; go to ACCESS. No req: stay IDLE.
- Winner selection: if ld_req && starve_cnt==STARVE_LIMIT, loader wins. Otherwise data > fetch > loader.
- starve_cnt: on a grant to data or fetch while ld_req=1, increment (saturate at STARVE_LIMIT). On loader grant or when ld_req=0 in IDLE, clear to 0.
- ACCESS: mem_* held stable; req inputs ignored. When cnt != 0, decrement. When cnt == 0 at posedge: for a read, rdata <= mem_rdata; for a write, rdata unchanged; owner done=1 for one cycle; mem_en=0, mem_we=0, busy=0; go to IDLE.
- Throughput: one access per LATENCY+1 cycles. The earliest regrant is the edge after done, so gnt never coincides with done.
- Requester rules: hold req/addr/we/wdata stable from assertion until gnt is seen. Deassert req in the cycle gnt is seen unless a back-to-back access is wanted. A req still high in IDLE after done is treated as a new request.
- Simultaneous requests: exactly one gnt per arbitration. Losers keep req and are served in later IDLE cycles by the same rules.
- rdata holds its value until the next read completion.

Test Plan:
- Single fetch: reset, fetch_req=1, fetch_addr=0x0010, mem returns 0xC105 -> fetch_gnt at edge 1; mem_en=1, addr=0x0010 for 2 cycles; fetch_done with rdata=0xC105 at edge 3; busy 1 during edges 1-3, 0 after.
- Store then load: data_we=1, addr=0x0020, wdata=0xBEEF -> mem_we=1 with wdata=0xBEEF, data_done, rdata unchanged; then load of 0x0020 -> rdata=0xBEEF.
- Contention: fetch_req and data_req both high in the same cycle -> data_gnt first; fetch_gnt on the edge after data_done; never two gnt in one cycle.
- Starvation: ld_req held while data/fetch alternate continuously -> after 4 non-loader grants the 5th grant is ld_gnt; starve_cnt returns to 0.
- Reset mid-access: assert reset one cycle after data_gnt -> no data_done; mem_en=0, busy=0, rdata=0 after the reset edge; the next request is served normally.
- LATENCY=1 build: back-to-back fetches with fetch_req held high -> gnt/done alternate every 2 cycles with sequential rdata values.
